// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the AHB-APB bridge (master) and the register-file completer (slave).
interface apb_slave_regfile_if #(
    parameter int ADDR_W = 8
);
    logic              p_sel;
    logic              p_enable;
    logic              p_write;
    logic [ADDR_W-1:0] p_addr;
    logic [31:0]       p_wdata;
    logic [3:0]        p_strb;
    logic [31:0]       p_rdata;
    logic              p_ready;
    logic              p_slverr;

    modport master (
        output p_sel, p_enable, p_write, p_addr, p_wdata, p_strb,
        input  p_rdata, p_ready, p_slverr
    );

    modport slave (
        input  p_sel, p_enable, p_write, p_addr, p_wdata, p_strb,
        output p_rdata, p_ready, p_slverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer: 32-bit register bank with programmable wait states and slave-error decode.
// Define APB_PSTRB_EN to honour p_strb byte strobes on writes; otherwise writes are full-word.
module apb_slave_regfile #(
    parameter int                  ADDR_W      = 8,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = NUM_REGS'(8'h80)
) (
    input  logic                     p_clk,
    input  logic                     p_reset,
    apb_slave_regfile_if.slave       apb,
    input  logic [32*NUM_REGS-1:0]   hw_in,
    output logic [32*NUM_REGS-1:0]   reg_out
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                     state_r;
    logic [3:0]                 cnt_r;
    logic [NUM_REGS-1:0][31:0]  regs_r;

    logic [NUM_REGS-1:0][31:0]  view_s;
    logic [ADDR_W-3:0]          idx_s;
    logic                       in_range_s;
    logic                       ro_s;
    logic [31:0]                rd_val_s;
    logic                       err_s;
    logic                       ready_s;
    logic                       wr_en_s;
    logic [3:0]                 strb_s;
    logic                       unused_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wd,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? wd[b*8 +: 8] : cur[b*8 +: 8];
        end
        return res;
    endfunction

`ifdef APB_PSTRB_EN
    assign strb_s = apb.p_strb;
`else
    assign strb_s = 4'b1111;
`endif

    // Bits that are intentionally not consumed in every configuration.
    assign unused_s = ^{hw_in, regs_r, apb.p_strb};

    // Architectural view of each register: RO slots mirror hardware status.
    always_comb begin
        view_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            view_s[i] = RO_MASK[i] ? hw_in[i*32 +: 32] : regs_r[i];
        end
        reg_out = view_s;
    end

    // Address decode and error classification on the address held in ACCESS.
    always_comb begin
        idx_s      = apb.p_addr[ADDR_W-1:2];
        in_range_s = 1'b0;
        ro_s       = 1'b0;
        rd_val_s   = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            in_range_s = in_range_s | (idx_s == (ADDR_W-2)'(i));
            ro_s       = ro_s | ((idx_s == (ADDR_W-2)'(i)) & RO_MASK[i]);
            rd_val_s   = rd_val_s | ({32{idx_s == (ADDR_W-2)'(i)}} & view_s[i]);
        end
        err_s   = !in_range_s || (apb.p_addr[1:0] != 2'b00) || (apb.p_write && ro_s);
        ready_s = (state_r == ACCESS) && (cnt_r == 4'd0);
        wr_en_s = ready_s && apb.p_sel && apb.p_write && !err_s;
    end

    // Response outputs depend only on registered state for p_ready; data/error are gated by it.
    always_comb begin
        apb.p_ready  = ready_s;
        apb.p_slverr = ready_s && err_s;
        apb.p_rdata  = (ready_s && !err_s && !apb.p_write) ? rd_val_s : 32'h0;
    end

    // Transfer FSM, wait-state counter and register storage.
    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            regs_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (apb.p_sel && !apb.p_enable) begin
                        state_r <= ACCESS;
                        cnt_r   <= 4'(WAIT_STATES);
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= 4'd0;
                    end
                end
                ACCESS: begin
                    if (!apb.p_sel) begin
                        state_r <= IDLE;
                        cnt_r   <= 4'd0;
                    end else if (cnt_r == 4'd0) begin
                        state_r <= IDLE;
                    end else if (apb.p_enable) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        state_r <= ACCESS;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase

            // A p_sel drop at the completing edge still suppresses the write.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_s && (idx_s == (ADDR_W-2)'(i))) begin
                    regs_r[i] <= merge_bytes(regs_r[i], apb.p_wdata, strb_s);
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed testbench for apb_slave_regfile with a response scoreboard and register model.
module tb_apb_slave_regfile;
    localparam int NR = 8;
    localparam int WS = 1;

    typedef struct {
        logic        slverr;
        logic [31:0] rdata;
    } exp_t;

    logic              p_clk = 1'b0;
    logic              p_reset;
    logic [32*NR-1:0]  hw_in;
    logic [32*NR-1:0]  reg_out;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [31:0] model[NR];

    always #5 p_clk = ~p_clk;

    apb_slave_regfile_if #(.ADDR_W(8)) bus();

    apb_slave_regfile #(
        .ADDR_W(8), .NUM_REGS(NR), .WAIT_STATES(WS), .RO_MASK(8'h80)
    ) dut (
        .p_clk(p_clk), .p_reset(p_reset), .apb(bus), .hw_in(hw_in), .reg_out(reg_out)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_view(input int i);
        return (i == 7) ? hw_in[i*32 +: 32] : model[i];
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            check32($sformatf("%s_reg%0d", tag, i), reg_out[i*32 +: 32], model_view(i));
        end
    endtask

    task automatic idle_cycle();
        bus.p_sel    = 1'b0;
        bus.p_enable = 1'b0;
        @(posedge p_clk); #1;
    endtask

    // One complete APB transfer; leaves p_sel asserted so a following call is back-to-back.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input string tag);
        exp_t       e;
        exp_t       got;
        logic [5:0] idx;
        logic       err;
        logic       done;
        idx = addr[7:2];
        err = (idx >= 6'd8) || (addr[1:0] != 2'b00) || (wr && (idx == 6'd7));
        e.slverr = err;
        e.rdata  = (!err && !wr) ? model_view(int'(idx)) : 32'h0;
        sb.push_back(e);
        bus.p_sel    = 1'b1;
        bus.p_enable = 1'b0;
        bus.p_write  = wr;
        bus.p_addr   = addr;
        bus.p_wdata  = wd;
        bus.p_strb   = st;
        @(posedge p_clk); #1;
        bus.p_enable = 1'b1;
        done = 1'b0;
        for (int k = 1; k <= 16 && !done; k++) begin
            @(negedge p_clk);
            if (bus.p_ready) begin
                got = sb.pop_front();
                check32({tag, "_latency"}, 32'(k), 32'(WS + 1));
                check32({tag, "_slverr"}, {31'h0, bus.p_slverr}, {31'h0, got.slverr});
                check32({tag, "_rdata"}, bus.p_rdata, got.rdata);
                done = 1'b1;
            end else begin
                check32({tag, "_wait_rdata"}, bus.p_rdata, 32'h0);
                check32({tag, "_wait_slverr"}, {31'h0, bus.p_slverr}, 32'h0);
            end
            @(posedge p_clk); #1;
        end
        if (!done) begin
            check32({tag, "_timeout"}, 32'h0, 32'h1);
            void'(sb.pop_front());
        end
        if (!err && wr) begin
`ifdef APB_PSTRB_EN
            for (int b = 0; b < 4; b++) begin
                if (st[b]) model[idx[2:0]][b*8 +: 8] = wd[b*8 +: 8];
            end
`else
            model[idx[2:0]] = wd;
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        bus.p_sel = 1'b0; bus.p_enable = 1'b0; bus.p_write = 1'b0;
        bus.p_addr = 8'h00; bus.p_wdata = 32'h0; bus.p_strb = 4'h0;
        for (int i = 0; i < NR; i++) begin
            hw_in[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);
            model[i] = 32'h0;
        end
        p_reset = 1'b1;
        repeat (2) @(posedge p_clk);
        @(negedge p_clk);
        check32("reset_ready", {31'h0, bus.p_ready}, 32'h0);
        check32("reset_slverr", {31'h0, bus.p_slverr}, 32'h0);
        check32("reset_rdata", bus.p_rdata, 32'h0);
        check_regs("reset");
        @(posedge p_clk); #1;
        p_reset = 1'b0;
        @(negedge p_clk);
        check32("post_reset_ready", {31'h0, bus.p_ready}, 32'h0);
        @(posedge p_clk); #1;

        xfer(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, "wr04");
        idle_cycle();
        check32("wr04_regout", reg_out[63:32], 32'hDEADBEEF);
        xfer(1'b0, 8'h04, 32'h0, 4'hF, "rd04");
        idle_cycle();
        check32("rd04_model", model[1], 32'hDEADBEEF);

        xfer(1'b0, 8'h1C, 32'h0, 4'hF, "rd_ro7");
        xfer(1'b1, 8'h1C, 32'h12345678, 4'hF, "wr_ro7");
        xfer(1'b0, 8'h20, 32'h0, 4'hF, "rd_oor");
        xfer(1'b1, 8'h20, 32'h87654321, 4'hF, "wr_oor");
        xfer(1'b0, 8'h05, 32'h0, 4'hF, "rd_mis");
        xfer(1'b1, 8'h05, 32'hFFFF0000, 4'hF, "wr_mis");
        xfer(1'b1, 8'hFC, 32'hA5A5A5A5, 4'hF, "wr_top");
        idle_cycle();
        check_regs("after_errors");

        xfer(1'b1, 8'h00, 32'h00000011, 4'hF, "b2b_wr");
        xfer(1'b0, 8'h00, 32'h0, 4'hF, "b2b_rd");
        idle_cycle();

        // Abort: p_sel drops during ACCESS.
        bus.p_sel = 1'b1; bus.p_enable = 1'b0; bus.p_write = 1'b1;
        bus.p_addr = 8'h08; bus.p_wdata = 32'h55555555;
        @(posedge p_clk); #1;
        bus.p_sel = 1'b0;
        @(negedge p_clk);
        check32("abort_ready0", {31'h0, bus.p_ready}, 32'h0);
        @(posedge p_clk); #1;
        @(negedge p_clk);
        check32("abort_ready1", {31'h0, bus.p_ready}, 32'h0);
        check_regs("abort");
        @(posedge p_clk); #1;
        xfer(1'b0, 8'h08, 32'h0, 4'hF, "abort_rd08");
        idle_cycle();

        // Reset in the middle of an ACCESS phase.
        bus.p_sel = 1'b1; bus.p_enable = 1'b0; bus.p_write = 1'b1;
        bus.p_addr = 8'h0C; bus.p_wdata = 32'h77777777;
        @(posedge p_clk); #1;
        bus.p_enable = 1'b1;
        p_reset = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        @(negedge p_clk);
        check32("midrst_ready", {31'h0, bus.p_ready}, 32'h0);
        check_regs("midrst");
        bus.p_sel = 1'b0; bus.p_enable = 1'b0;
        @(posedge p_clk); #1;
        p_reset = 1'b0;
        idle_cycle();
        xfer(1'b0, 8'h04, 32'h0, 4'hF, "postrst_rd04");
        xfer(1'b1, 8'h0C, 32'h00C0FFEE, 4'hF, "postrst_wr0c");
        xfer(1'b0, 8'h0C, 32'h0, 4'hF, "postrst_rd0c");
        idle_cycle();

        // Byte strobes on reg0 (zero after the reset above).
        xfer(1'b1, 8'h00, 32'hAABBCCDD, 4'b0101, "strb_wr");
        idle_cycle();
`ifdef APB_PSTRB_EN
        check32("strb_reg0", reg_out[31:0], 32'h00BB00DD);
`else
        check32("strb_reg0", reg_out[31:0], 32'hAABBCCDD);
`endif
        xfer(1'b1, 8'h00, 32'h11223344, 4'b0000, "strb_none");
        xfer(1'b0, 8'h00, 32'h0, 4'b0000, "strb_rd");
        idle_cycle();

        for (int n = 0; n < 6; n++) begin
            a = {3'b000, 3'($urandom_range(0, 6)), 2'b00};
            d = $urandom;
            xfer(1'b1, a, d, 4'hF, $sformatf("rnd_wr%0d", n));
            xfer(1'b0, a, 32'h0, 4'hF, $sformatf("rnd_rd%0d", n));
        end
        idle_cycle();
        check_regs("final");
        check32("sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
